food: RTL and testbench
=======================

FOOD -- requirements
Module: food

Interface
REQ-001 Parameter GAME_WIDTH, default 20: playfield columns (x 1..GAME_WIDTH); SHALL be 16..30.
REQ-002 Parameter GAME_HEIGHT, default 12: playfield rows (y 1..GAME_HEIGHT); SHALL be 8..14.
REQ-003 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; 0 SHALL be substituted with 16'h0001.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 i_pos_x  in  5  / i_pos_y  in  4: snake cell currently presented by the snake scan.
REQ-007 i_pos_valid  in  1: i_pos_x/y holds a live snake cell this cycle.
REQ-008 i_pos_first  in  1: presented cell is the head (start of scan).
REQ-009 i_tick_done  in  1: one-cycle pulse, scan of the whole body finished.
REQ-010 i_failure  in  1: snake collision detected.
REQ-011 o_eat  out  1: one-cycle pulse, snake grows by one (drives snake i_eat).
REQ-012 o_food_x  out  5 / o_food_y  out  4: food cell (or pending candidate).
REQ-013 o_food_valid  out  1: food is placed and displayable.
REQ-014 o_score  out  8: food eaten count, saturating.

Function
REQ-015 16-bit Fibonacci LFSR, taps 16,14,13,11, SHALL advance every clock outside reset, independent of state.
REQ-016 Candidate x SHALL be lfsr[4:0]+1 if lfsr[4:0] < GAME_WIDTH, else lfsr[4:0]-GAME_WIDTH+1; candidate y likewise from lfsr[11:8] with GAME_HEIGHT; result always in range.
REQ-017 States: PLACE, ACTIVE, HALT; plus flags scanning and conflict.
REQ-018 PLACE, cycle with i_pos_valid && i_pos_first: food regs <= candidate, scanning <= 1, conflict <= (pos == candidate).
REQ-019 PLACE, scanning, other cycles with i_pos_valid && pos == food regs: conflict <= 1.
REQ-020 PLACE, i_tick_done && scanning: if conflict == 0 -> ACTIVE, o_food_valid <= 1; else stay PLACE; scanning <= 0 in both cases.
REQ-021 PLACE, i_tick_done while scanning == 0 (partial scan): ignored, no transition.
REQ-022 ACTIVE, cycle with i_pos_valid && i_pos_first && pos == food regs: next cycle o_eat = 1 for exactly one cycle, o_score += 1 (saturate at 255), o_food_valid <= 0, state <= PLACE.
REQ-023 ACTIVE, non-head cells matching food SHALL not trigger eat.
REQ-024 o_eat SHALL never be high two consecutive cycles.
REQ-025 Any state, i_failure == 1: state <= HALT; failure has priority over eat and placement in the same cycle.
REQ-026 HALT: o_eat held 0; food regs, o_food_valid, o_score frozen; only exit is reset.
REQ-027 o_food_x/y SHALL show the pending candidate in PLACE (with o_food_valid 0).

Reset
REQ-028 On rst (asynchronously): lfsr = LFSR_SEED, state = PLACE, scanning = 0, conflict = 0, o_food_x = 0, o_food_y = 0, o_food_valid = 0, o_eat = 0, o_score = 0.
REQ-029 Reset mid-scan or mid-eat SHALL discard the pending pulse; the first post-reset placement requires a full scan (i_pos_first then i_tick_done).

Verification
REQ-030 Mapping: force lfsr[4:0] to 0, 19, 31 with GAME_WIDTH 20 -> candidate x 1, 20, 12; lfsr[11:8] 15 with GAME_HEIGHT 12 -> y 4.
REQ-031 Clean placement: reset, scan head (3,5) then tick_done, candidate not (3,5) -> o_food_valid = 1 the cycle after tick_done, food in 1..20 x 1..12.
REQ-032 Conflict: in PLACE, present body cell equal to latched o_food_x/y mid-scan, then tick_done -> o_food_valid stays 0; next clean scan -> o_food_valid = 1.
REQ-033 Eat: ACTIVE food (7,4), present head (7,4) with i_pos_first -> o_eat 1 for one cycle next cycle, o_score 0->1, o_food_valid 0; same cell as non-head -> no eat.
REQ-034 Saturation: o_score 255, eat again -> o_eat pulses, o_score stays 255.
REQ-035 Failure: ACTIVE food (7,4), i_failure with head (7,4) same cycle -> o_eat stays 0, state HALT, outputs frozen until rst.

Source files
------------

// File: rtl/food_if.sv
// Snake-side bus of the food block: body scan in, food/eat/score out.
// The food block takes the slave modport; the snake/driver side takes master.
interface food_if;
  logic [4:0] i_pos_x;
  logic [3:0] i_pos_y;
  logic       i_pos_valid;
  logic       i_pos_first;
  logic       i_tick_done;
  logic       i_failure;
  logic       o_eat;
  logic [4:0] o_food_x;
  logic [3:0] o_food_y;
  logic       o_food_valid;
  logic [7:0] o_score;

  modport slave (
    input  i_pos_x, i_pos_y, i_pos_valid, i_pos_first, i_tick_done, i_failure,
    output o_eat, o_food_x, o_food_y, o_food_valid, o_score
  );

  modport master (
    output i_pos_x, i_pos_y, i_pos_valid, i_pos_first, i_tick_done, i_failure,
    input  o_eat, o_food_x, o_food_y, o_food_valid, o_score
  );
endinterface

// File: rtl/food.sv
// Food placement for the snake game: an LFSR picks a candidate cell, a full body
// scan rejects candidates under the snake, and a head hit on the food raises o_eat.
module food #(
  parameter int          GAME_WIDTH  = 20,
  parameter int          GAME_HEIGHT = 12,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic   clk,
  input logic   rst,
  food_if.slave bus
);

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [4:0]  W_X  = 5'(GAME_WIDTH);
  localparam logic [3:0]  W_Y  = 4'(GAME_HEIGHT);

  typedef enum logic [1:0] {
    ST_PLACE  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  // Fold the raw LFSR field into 1..N; the field is always below 2*N.
  function automatic logic [4:0] map_x(input logic [4:0] v);
    logic [4:0] r;
    if (v < W_X) r = v + 5'd1;
    else         r = v - W_X + 5'd1;
    return r;
  endfunction

  function automatic logic [3:0] map_y(input logic [3:0] v);
    logic [3:0] r;
    if (v < W_Y) r = v + 4'd1;
    else         r = v - W_Y + 4'd1;
    return r;
  endfunction

  state_t     r_state;
  state_t     w_state_next;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic       r_scanning, w_scanning_next;
  logic       r_conflict, w_conflict_next;
  logic [4:0] r_food_x, w_food_x_next;
  logic [3:0] r_food_y, w_food_y_next;
  logic       r_food_valid, w_food_valid_next;
  logic       r_eat, w_eat_next;
  logic [7:0] r_score, w_score_next;

  logic [4:0] w_cand_x;
  logic [3:0] w_cand_y;
  logic       w_head;
  logic       w_on_food;
  logic       w_on_cand;
  logic       w_body_hit;

  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_cand_x    = map_x(r_lfsr[4:0]);
  assign w_cand_y    = map_y(r_lfsr[11:8]);
  assign w_head      = bus.i_pos_valid & bus.i_pos_first;
  assign w_on_food   = (bus.i_pos_x == r_food_x) && (bus.i_pos_y == r_food_y);
  assign w_on_cand   = (bus.i_pos_x == w_cand_x) && (bus.i_pos_y == w_cand_y);
  assign w_body_hit  = bus.i_pos_valid & ~bus.i_pos_first & w_on_food;

  always_comb begin
    w_state_next      = r_state;
    w_scanning_next   = r_scanning;
    w_conflict_next   = r_conflict;
    w_food_x_next     = r_food_x;
    w_food_y_next     = r_food_y;
    w_food_valid_next = r_food_valid;
    w_eat_next        = 1'b0;
    w_score_next      = r_score;
    if (bus.i_failure) begin
      w_state_next = ST_HALT;
    end else begin
      case (r_state)
        ST_PLACE: begin
          if (w_head) begin
            w_food_x_next   = w_cand_x;
            w_food_y_next   = w_cand_y;
            w_scanning_next = 1'b1;
            w_conflict_next = w_on_cand;
          end else if (r_scanning && bus.i_tick_done) begin
            // A body cell landing on the food in the final cycle still counts.
            w_scanning_next = 1'b0;
            w_conflict_next = 1'b0;
            if (!(r_conflict || w_body_hit)) begin
              w_state_next      = ST_ACTIVE;
              w_food_valid_next = 1'b1;
            end else begin
              w_state_next = ST_PLACE;
            end
          end else if (r_scanning && w_body_hit) begin
            w_conflict_next = 1'b1;
          end else begin
            w_conflict_next = r_conflict;
          end
        end
        ST_ACTIVE: begin
          if (w_head && w_on_food) begin
            w_eat_next        = 1'b1;
            w_score_next      = (r_score == 8'hFF) ? 8'hFF : r_score + 8'd1;
            w_food_valid_next = 1'b0;
            w_state_next      = ST_PLACE;
          end else begin
            w_state_next = ST_ACTIVE;
          end
        end
        ST_HALT: begin
          w_state_next = ST_HALT;
        end
        default: begin
          w_state_next      = ST_PLACE;
          w_scanning_next   = 1'b0;
          w_conflict_next   = 1'b0;
          w_food_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr       <= SEED;
      r_state      <= ST_PLACE;
      r_scanning   <= 1'b0;
      r_conflict   <= 1'b0;
      r_food_x     <= 5'd0;
      r_food_y     <= 4'd0;
      r_food_valid <= 1'b0;
      r_eat        <= 1'b0;
      r_score      <= 8'd0;
    end else begin
      r_lfsr       <= w_lfsr_next;
      r_state      <= w_state_next;
      r_scanning   <= w_scanning_next;
      r_conflict   <= w_conflict_next;
      r_food_x     <= w_food_x_next;
      r_food_y     <= w_food_y_next;
      r_food_valid <= w_food_valid_next;
      r_eat        <= w_eat_next;
      r_score      <= w_score_next;
    end
  end

  assign bus.o_eat        = r_eat;
  assign bus.o_food_x     = r_food_x;
  assign bus.o_food_y     = r_food_y;
  assign bus.o_food_valid = r_food_valid;
  assign bus.o_score      = r_score;

endmodule

// File: tb/tb_food.sv
// Directed bench for food: hand-computed placements from the reset seed, mapping
// corners, conflict rejection, eat/score saturation, failure halt, async reset.
module tb_food;
  localparam int GW = 20;
  localparam int GH = 12;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_score;
  logic [15:0] m_lfsr;

  food_if bus ();

  food #(.GAME_WIDTH(GW), .GAME_HEIGHT(GH), .LFSR_SEED(16'hACE1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  function automatic logic [4:0] exp_x(input logic [4:0] v);
    return 5'((int'(v) % GW) + 1);
  endfunction

  function automatic logic [3:0] exp_y(input logic [3:0] v);
    return 4'((int'(v) % GH) + 1);
  endfunction

  // Reference LFSR, used only to time head presentations.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic idle();
    bus.i_pos_x = 5'd0; bus.i_pos_y = 4'd0;
    bus.i_pos_valid = 1'b0; bus.i_pos_first = 1'b0;
    bus.i_tick_done = 1'b0; bus.i_failure = 1'b0;
  endtask

  task automatic drive_head(input logic [4:0] x, input logic [3:0] y);
    bus.i_pos_x = x; bus.i_pos_y = y;
    bus.i_pos_valid = 1'b1; bus.i_pos_first = 1'b1;
    @(negedge clk);
    idle();
  endtask

  task automatic drive_tick();
    bus.i_tick_done = 1'b1;
    @(negedge clk);
    idle();
  endtask

  task automatic place_now();
    drive_head(5'd31, 4'd15);
    drive_tick();
  endtask

  task automatic eat_now();
    drive_head(bus.o_food_x, bus.o_food_y);
  endtask

  task automatic wait_lfsr(input logic [15:0] mask, input logic [15:0] val, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ((m_lfsr & mask) == val) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_cand(input logic [4:0] tx, input logic [3:0] ty, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (exp_x(m_lfsr[4:0]) == tx && exp_y(m_lfsr[11:8]) == ty) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.i_pos_valid = 1'b1; bus.i_pos_first = 1'b1; bus.i_tick_done = 1'b1;
    repeat (2) @(negedge clk);
    idle();
    checks++; if (bus.o_eat !== 1'b0) begin errors++; $display("FAIL reset_eat: got %0b want 0", bus.o_eat); end
    checks++; if (bus.o_food_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.o_food_valid); end
    checks++; if (bus.o_food_x !== 5'd0 || bus.o_food_y !== 4'd0) begin errors++; $display("FAIL reset_food: got (%0d,%0d) want (0,0)", bus.o_food_x, bus.o_food_y); end
    checks++; if (bus.o_score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", bus.o_score); end
  endtask

  task automatic test_clean_place();
    // Seed ACE1: field[4:0]=1 -> x 2, field[11:8]=12 -> y 1.
    rst = 1'b0;
    drive_head(5'd3, 4'd5);
    checks++; if (bus.o_food_x !== 5'd2 || bus.o_food_y !== 4'd1 || bus.o_food_valid !== 1'b0) begin
      errors++; $display("FAIL pending_cand: got (%0d,%0d) v%0b want (2,1) v0", bus.o_food_x, bus.o_food_y, bus.o_food_valid); end
    drive_tick();
    checks++; if (bus.o_food_valid !== 1'b1) begin errors++; $display("FAIL clean_valid: got %0b want 1", bus.o_food_valid); end
    checks++; if (bus.o_food_x !== 5'd2 || bus.o_food_y !== 4'd1) begin errors++; $display("FAIL clean_food: got (%0d,%0d) want (2,1)", bus.o_food_x, bus.o_food_y); end
  endtask

  task automatic test_eat();
    bus.i_pos_x = 5'd2; bus.i_pos_y = 4'd1; bus.i_pos_valid = 1'b1; bus.i_pos_first = 1'b0;
    @(negedge clk);
    idle();
    checks++; if (bus.o_eat !== 1'b0 || bus.o_food_valid !== 1'b1) begin
      errors++; $display("FAIL body_no_eat: got eat %0b valid %0b want 0 1", bus.o_eat, bus.o_food_valid); end
    drive_head(5'd2, 4'd1);
    exp_score = 1;
    checks++; if (bus.o_eat !== 1'b1) begin errors++; $display("FAIL eat_pulse: got %0b want 1", bus.o_eat); end
    checks++; if (bus.o_score !== 8'd1 || bus.o_food_valid !== 1'b0) begin
      errors++; $display("FAIL eat_score: got %0d v%0b want 1 v0", bus.o_score, bus.o_food_valid); end
    @(negedge clk);
    checks++; if (bus.o_eat !== 1'b0) begin errors++; $display("FAIL eat_single: got %0b want 0", bus.o_eat); end
  endtask

  task automatic test_mapping();
    logic [15:0] vals [4];
    logic [15:0] masks [4];
    logic [4:0]  want [4];
    bit ok;
    vals  = '{16'h0000, 16'h0013, 16'h001F, 16'h0F00};
    masks = '{16'h001F, 16'h001F, 16'h001F, 16'h0F00};
    want  = '{5'd1, 5'd20, 5'd12, 5'd4};
    for (int i = 0; i < 4; i++) begin
      wait_lfsr(masks[i], vals[i], ok);
      checks++; if (!ok) begin errors++; $display("FAIL map_wait%0d: got timeout want lfsr hit", i); end
      place_now();
      if (i < 3) begin
        checks++; if (bus.o_food_x !== want[i]) begin errors++; $display("FAIL map_x%0d: got %0d want %0d", i, bus.o_food_x, want[i]); end
      end else begin
        checks++; if (bus.o_food_y !== want[i][3:0]) begin errors++; $display("FAIL map_y: got %0d want %0d", bus.o_food_y, want[i][3:0]); end
      end
      eat_now();
      exp_score++;
      checks++; if (bus.o_eat !== 1'b1 || bus.o_score !== 8'(exp_score)) begin
        errors++; $display("FAIL map_eat%0d: got eat %0b score %0d want 1 %0d", i, bus.o_eat, bus.o_score, exp_score); end
    end
  endtask

  task automatic test_conflict();
    logic [4:0] cx;
    logic [3:0] cy;
    cx = exp_x(m_lfsr[4:0]);
    cy = exp_y(m_lfsr[11:8]);
    drive_head(5'd31, 4'd15);
    checks++; if (bus.o_food_x !== cx || bus.o_food_y !== cy) begin
      errors++; $display("FAIL conf_cand: got (%0d,%0d) want (%0d,%0d)", bus.o_food_x, bus.o_food_y, cx, cy); end
    bus.i_pos_x = cx; bus.i_pos_y = cy; bus.i_pos_valid = 1'b1; bus.i_pos_first = 1'b0;
    @(negedge clk);
    idle();
    drive_tick();
    checks++; if (bus.o_food_valid !== 1'b0) begin errors++; $display("FAIL conf_reject: got %0b want 0", bus.o_food_valid); end
    place_now();
    checks++; if (bus.o_food_valid !== 1'b1) begin errors++; $display("FAIL conf_retry: got %0b want 1", bus.o_food_valid); end
    eat_now();
    exp_score++;
    checks++; if (bus.o_score !== 8'(exp_score)) begin errors++; $display("FAIL conf_eat: got %0d want %0d", bus.o_score, exp_score); end
  endtask

  task automatic test_saturation();
    while (exp_score < 255) begin
      place_now();
      eat_now();
      exp_score++;
      checks++; if (bus.o_eat !== 1'b1 || bus.o_score !== 8'(exp_score)) begin
        errors++; $display("FAIL sat_step: got eat %0b score %0d want 1 %0d", bus.o_eat, bus.o_score, exp_score); end
    end
    place_now();
    eat_now();
    checks++; if (bus.o_eat !== 1'b1 || bus.o_score !== 8'd255) begin
      errors++; $display("FAIL sat_hold: got eat %0b score %0d want 1 255", bus.o_eat, bus.o_score); end
    @(negedge clk);
    checks++; if (bus.o_eat !== 1'b0) begin errors++; $display("FAIL sat_single: got %0b want 0", bus.o_eat); end
  endtask

  task automatic test_failure();
    bit ok;
    wait_cand(5'd7, 4'd4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fail_wait: got timeout want candidate (7,4)"); end
    place_now();
    checks++; if (bus.o_food_x !== 5'd7 || bus.o_food_y !== 4'd4 || bus.o_food_valid !== 1'b1) begin
      errors++; $display("FAIL fail_place: got (%0d,%0d) v%0b want (7,4) v1", bus.o_food_x, bus.o_food_y, bus.o_food_valid); end
    bus.i_failure = 1'b1;
    drive_head(5'd7, 4'd4);
    checks++; if (bus.o_eat !== 1'b0 || bus.o_score !== 8'd255 || bus.o_food_valid !== 1'b1) begin
      errors++; $display("FAIL fail_prio: got eat %0b score %0d v%0b want 0 255 1", bus.o_eat, bus.o_score, bus.o_food_valid); end
    drive_head(5'd7, 4'd4);
    checks++; if (bus.o_eat !== 1'b0) begin errors++; $display("FAIL halt_no_eat: got %0b want 0", bus.o_eat); end
    place_now();
    checks++; if (bus.o_food_x !== 5'd7 || bus.o_food_y !== 4'd4 || bus.o_food_valid !== 1'b1 || bus.o_score !== 8'd255) begin
      errors++; $display("FAIL halt_frozen: got (%0d,%0d) v%0b s%0d want (7,4) v1 s255", bus.o_food_x, bus.o_food_y, bus.o_food_valid, bus.o_score); end
  endtask

  task automatic test_reset_mid_eat();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_head(5'd3, 4'd5);
    drive_tick();
    checks++; if (bus.o_food_x !== 5'd2 || bus.o_food_y !== 4'd1 || bus.o_food_valid !== 1'b1) begin
      errors++; $display("FAIL reseed_place: got (%0d,%0d) v%0b want (2,1) v1", bus.o_food_x, bus.o_food_y, bus.o_food_valid); end
    bus.i_pos_x = 5'd2; bus.i_pos_y = 4'd1; bus.i_pos_valid = 1'b1; bus.i_pos_first = 1'b1;
    @(posedge clk);
    #1;
    idle();
    checks++; if (bus.o_eat !== 1'b1) begin errors++; $display("FAIL mid_eat_pulse: got %0b want 1", bus.o_eat); end
    rst = 1'b1;
    #1;
    checks++; if (bus.o_eat !== 1'b0 || bus.o_score !== 8'd0 || bus.o_food_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got eat %0b score %0d v%0b want 0 0 0", bus.o_eat, bus.o_score, bus.o_food_valid); end
    @(negedge clk);
    rst = 1'b0;
    drive_tick();
    checks++; if (bus.o_food_valid !== 1'b0) begin errors++; $display("FAIL partial_scan: got %0b want 0", bus.o_food_valid); end
    // One step past ACE1 is 59C3: field[4:0]=3 -> x 4, field[11:8]=9 -> y 10.
    place_now();
    checks++; if (bus.o_food_x !== 5'd4 || bus.o_food_y !== 4'd10 || bus.o_food_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_place: got (%0d,%0d) v%0b want (4,10) v1", bus.o_food_x, bus.o_food_y, bus.o_food_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_score = 0;
    rst = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_clean_place();
    test_eat();
    test_mapping();
    test_conflict();
    test_saturation();
    test_failure();
    test_reset_mid_eat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
